// File: rtl/key_event_scheduler.sv
// Turns PS/2 key events into a queued ASCII stream with typematic suppression and Caps Lock.
// Optional SHIFT_MODIFIER_EN: Left/Right Shift invert letter case while held.
module key_event_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [511:0]  key_down,
    input  logic [8:0]    last_change,
    input  logic          key_valid,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [7:0]    out_ascii,
    output logic          caps_on,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic          missed
);

    localparam logic [AW:0] FullCnt = DEPTH[AW:0];

    typedef enum logic {StIdle, StClassify} state_e;

    state_e      state_q, state_d;
    logic [8:0]  code_q, code_d;
    logic [8:0]  held_code_q, held_code_d;
    logic        held_flag_q, held_flag_d;
    logic        caps_q, caps_d;
    logic        overflow_q, overflow_d;
    logic        missed_q, missed_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;

    logic        is_press, is_shift, upper;
    logic        letter_hit;
    logic [7:0]  letter_idx;
    logic        push, pop, full, push_ok;
    logic [7:0]  push_char;

    assign is_press = key_down[last_change];

`ifdef SHIFT_MODIFIER_EN
    assign is_shift = (last_change == 9'h012) || (last_change == 9'h059);
    assign upper    = caps_q ^ (key_down[9'h012] | key_down[9'h059]);
`else
    assign is_shift = 1'b0;
    assign upper    = caps_q;
`endif

    // Set-2 make codes for A..Z; idx is the offset from 'A'.
    always_comb begin
        letter_hit = 1'b1;
        letter_idx = 8'd0;
        case (code_q)
            9'h01C: letter_idx = 8'd0;
            9'h032: letter_idx = 8'd1;
            9'h021: letter_idx = 8'd2;
            9'h023: letter_idx = 8'd3;
            9'h024: letter_idx = 8'd4;
            9'h02B: letter_idx = 8'd5;
            9'h034: letter_idx = 8'd6;
            9'h033: letter_idx = 8'd7;
            9'h043: letter_idx = 8'd8;
            9'h03B: letter_idx = 8'd9;
            9'h042: letter_idx = 8'd10;
            9'h04B: letter_idx = 8'd11;
            9'h03A: letter_idx = 8'd12;
            9'h031: letter_idx = 8'd13;
            9'h044: letter_idx = 8'd14;
            9'h04D: letter_idx = 8'd15;
            9'h015: letter_idx = 8'd16;
            9'h02D: letter_idx = 8'd17;
            9'h01B: letter_idx = 8'd18;
            9'h02C: letter_idx = 8'd19;
            9'h03C: letter_idx = 8'd20;
            9'h02A: letter_idx = 8'd21;
            9'h01D: letter_idx = 8'd22;
            9'h022: letter_idx = 8'd23;
            9'h035: letter_idx = 8'd24;
            9'h01A: letter_idx = 8'd25;
            default: letter_hit = 1'b0;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_char = 8'h00;
        if (state_q == StClassify) begin
            if (letter_hit) begin
                push      = 1'b1;
                push_char = (upper ? 8'h41 : 8'h61) + letter_idx;
            end else begin
                case (code_q)
                    9'h029: begin push = 1'b1; push_char = 8'h20; end
                    9'h05A: begin push = 1'b1; push_char = 8'h0D; end
                    9'h066: begin push = 1'b1; push_char = 8'h08; end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        held_code_d = held_code_q;
        held_flag_d = held_flag_q;
        caps_d      = caps_q;
        missed_d    = missed_q;
        case (state_q)
            StIdle: begin
                if (key_valid) begin
                    if (is_press) begin
                        if (!(held_flag_q && last_change == held_code_q)) begin
                            code_d  = last_change;
                            state_d = StClassify;
                            if (!is_shift) begin
                                held_code_d = last_change;
                                held_flag_d = 1'b1;
                            end
                        end
                    end else if (last_change == held_code_q) begin
                        held_flag_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                if (key_valid) missed_d = 1'b1;
                if (code_q == 9'h058) caps_d = ~caps_q;
            end
        endcase
    end

    assign full    = (count_q == FullCnt);
    assign pop     = (count_q != '0) && out_ready;
    assign push_ok = push && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_char;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (push && !push_ok) overflow_d = 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        else if (pop && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            code_q      <= '0;
            held_code_q <= '0;
            held_flag_q <= 1'b0;
            caps_q      <= 1'b0;
            overflow_q  <= 1'b0;
            missed_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            held_code_q <= held_code_d;
            held_flag_q <= held_flag_d;
            caps_q      <= caps_d;
            overflow_q  <= overflow_d;
            missed_q    <= missed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_ascii  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign caps_on    = caps_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench: stimulus queues expected characters, a negedge monitor checks each pop.
module tb_key_event_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic [511:0]  key_down;
    logic [8:0]    last_change;
    logic          key_valid;
    logic          out_ready;
    logic          out_valid;
    logic [7:0]    out_ascii;
    logic          caps_on;
    logic [3:0]    fifo_count;
    logic          overflow;
    logic          missed;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb [$];

    key_event_scheduler #(.DEPTH(8), .AW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_ascii   (out_ascii),
        .caps_on     (caps_on),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .missed      (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head character must match the scoreboard front.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got %0h, expected nothing queued", out_ascii);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (out_ascii != e) begin
                    fails++;
                    $display("FAIL out_ascii: got %0h, expected %0h", out_ascii, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [8:0] c);
        key_down[c] = 1'b1;
        last_change = c;
        key_valid   = 1'b1;
        tick();
        key_valid   = 1'b0;
        tick();
    endtask

    task automatic release_key(input logic [8:0] c);
        key_down[c] = 1'b0;
        last_change = c;
        key_valid   = 1'b1;
        tick();
        key_valid   = 1'b0;
        tick();
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (fifo_count != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, int'(fifo_count), 0);
        check({name, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1; key_down = '0; last_change = '0; key_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_ascii", int'(out_ascii), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_caps", int'(caps_on), 0);
        check("rst_flags", int'({overflow, missed}), 0);

        // Press A: latency and head contents.
        key_down[9'h01C] = 1'b1; last_change = 9'h01C; key_valid = 1'b1;
        sb.push_back(8'h61);
        tick();
        key_valid = 1'b0;
        check("lat_t1_valid", int'(out_valid), 0);
        tick();
        check("lat_t2_valid", int'(out_valid), 1);
        check("a_ascii", int'(out_ascii), 8'h61);
        check("a_count", int'(fifo_count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_pop_count", int'(fifo_count), 0);
        check("a_pop_ascii", int'(out_ascii), 0);
        release_key(9'h01C);

        // Caps Lock toggles case.
        out_ready = 1'b1;
        press(9'h058); release_key(9'h058);
        check("caps_on", int'(caps_on), 1);
        sb.push_back(8'h42);
        press(9'h032); release_key(9'h032);
        press(9'h058); release_key(9'h058);
        check("caps_off", int'(caps_on), 0);
        wait_empty("caps_drain");

        // Typematic repeats of C suppressed until release.
        sb.push_back(8'h63);
        press(9'h021);
        for (int i = 0; i < 5; i++) press(9'h021);
        release_key(9'h021);
        sb.push_back(8'h63);
        press(9'h021);
        release_key(9'h021);
        wait_empty("repeat_drain");

        // Overflow: nine letters into an eight-deep FIFO.
        out_ready = 1'b0;
        key_down = '0;
        begin
            logic [8:0] codes [9];
            codes = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033, 9'h043};
            for (int i = 0; i < 9; i++) begin
                if (i < 8) sb.push_back(8'h61 + 8'(i));
                press(codes[i]);
            end
        end
        check("full_count", int'(fifo_count), 8);
        check("overflow", int'(overflow), 1);
        // J pushed in the same cycle as a pop.
        key_down[9'h03B] = 1'b1; last_change = 9'h03B; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        out_ready = 1'b1;
        sb.push_back(8'h6A);
        tick();
        out_ready = 1'b0;
        check("full_pushpop_count", int'(fifo_count), 8);
        out_ready = 1'b1;
        wait_empty("full_drain");

        // Back-to-back key_valid: second event lost.
        key_down = '0;
        check("missed_pre", int'(missed), 0);
        key_down[9'h01C] = 1'b1; key_down[9'h023] = 1'b1;
        sb.push_back(8'h61);
        last_change = 9'h01C; key_valid = 1'b1;
        tick();
        last_change = 9'h023;
        tick();
        key_valid = 1'b0;
        tick();
        check("missed", int'(missed), 1);
        wait_empty("missed_drain");

`ifdef SHIFT_MODIFIER_EN
        key_down = '0;
        press(9'h058);
        check("sh_caps", int'(caps_on), 1);
        key_down[9'h012] = 1'b1;
        press(9'h012);
        sb.push_back(8'h65);
        press(9'h024);
        release_key(9'h012);
        release_key(9'h024);
        sb.push_back(8'h45);
        press(9'h024);
        wait_empty("shift_drain");
`endif

        // Async reset mid-stream clears everything.
        out_ready = 1'b0;
        key_down = '0;
        press(9'h058);
        press(9'h01C);
        press(9'h032);
        check("pre_rst_count", int'(fifo_count), 2);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ascii", int'(out_ascii), 0);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_caps", int'(caps_on), 0);
        check("mid_rst_flags", int'({overflow, missed}), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
Sequences PS/2 keyboard events from the upstream keyboard decoder into an ordered stream of ASCII characters. The block detects fresh key presses, suppresses typematic repeats and tracks Caps Lock state. It classifies each scan code, queues printable and control characters in a small FIFO, and hands them to the display or text-buffer consumer over a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries (power of two, 2..64)
AW, 3, FIFO address width, log2(DEPTH)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
key_down  input  512  held-key bitmap from keyboard decoder
last_change  input  9  scan code of most recent make/break
key_valid  input  1  one-cycle pulse: last_change/key_down updated
out_ready  input  1  consumer accepts head character
out_valid  output  1  FIFO non-empty
out_ascii  output  8  head character; 8'h00 when empty
caps_on  output  1  current Caps Lock state
fifo_count  output  AW+1  occupied entries, 0..DEPTH
overflow  output  1  sticky: a character was dropped on full FIFO
missed  output  1  sticky: key_valid arrived while FSM busy

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; caps_on=0; FIFO empty; out_valid=0; out_ascii=8'h00; fifo_count=0.
  - overflow=0; missed=0; held_code=0; held_flag=0.
- FSM states: IDLE, CLASSIFY.
- IDLE, key_valid=1:
  - Press when key_down[last_change]=1. Release otherwise.
  - Press with last_change==held_code and held_flag=1 is a typematic repeat: ignored, stay IDLE.
  - Other press: latch code into code_r; held_code<=last_change; held_flag<=1; go CLASSIFY.
  - Release with last_change==held_code: held_flag<=0, stay IDLE. Other releases are ignored.
- CLASSIFY (exactly one cycle), then always back to IDLE:
  - 9'h058 Caps Lock: caps_on toggles; nothing enqueued.
  - Letters A..Z (standard set-2 codes, e.g. 1C=A, 32=B, 1A=Z): enqueue 8'h41+idx if upper, else 8'h61+idx. upper = caps_on (see optional feature).
  - 9'h029 enqueues 8'h20. 9'h05A enqueues 8'h0D. 9'h066 enqueues 8'h08.
  - Any other code: discarded, no FIFO write.
- key_valid while in CLASSIFY: event dropped; missed<=1 (sticky until rst).
- Latency: key_valid at cycle t → FIFO write at end of t+1 → out_valid=1 at t+2 if FIFO was empty.
- FIFO:
  - Circular buffer, wr/rd pointers of AW bits wrapping modulo DEPTH; count register of AW+1 bits.
  - out_ascii driven from the head entry, combinational from the registered array.
  - Pop when out_valid && out_ready.
  - Push on full without pop: character dropped, overflow<=1, count unchanged.
  - Push on full with same-cycle pop: both occur, count stays DEPTH.
  - Pop on empty: no effect. Simultaneous push and pop when non-full: count unchanged.
- Caps toggle takes effect from the next CLASSIFY. A letter classified in the same cycle as a toggle is impossible, since toggles occur only in CLASSIFY.
- rst mid-operation: all state cleared immediately, including queued characters.

Optional Feature:
Macro SHIFT_MODIFIER_EN.
- Defined:
  - Left Shift 9'h012 and Right Shift 9'h059 enter CLASSIFY as non-enqueuing codes.
  - upper = caps_on XOR (key_down[9'h012] | key_down[9'h059]), sampled in CLASSIFY.
  - Shift presses do not update held_code/held_flag, so a letter held under shift still suppresses its repeats.
- Undefined: upper = caps_on; shift codes are discarded as unknown, and they do update held_code.

Test Plan:
- Reset, then press A (key_valid, last_change=1C, key_down[1C]=1) → out_valid at t+2, out_ascii=8'h61, fifo_count=1; pulse out_ready → count 0, out_ascii=8'h00.
- Press/release Caps Lock (058), then press B (032) → caps_on=1, out_ascii=8'h42; repeat Caps Lock → caps_on=0.
- Hold C (021), send 5 repeat key_valid pulses with same code → exactly one 8'h63 queued; release, press again → second 8'h63.
- out_ready=0, press DEPTH+1 distinct letters → fifo_count=8, overflow=1, the first 8 characters drain in order; then at full, push+pop in the same cycle → count stays 8.
- key_valid on consecutive cycles (A then D) → only A queued, missed=1; assert rst mid-stream → all outputs return to reset values.
- SHIFT_MODIFIER_EN, caps_on=1, hold 012, press E (024) → 8'h65; release shift, press E → 8'h45.
